// File: rtl/comparator_pkg.sv
// Shared types and helpers for the sequential magnitude comparator:
// FSM state encoding, verdict encoding and a constant-friendly log2.
package comparator_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        RES_GT = 2'd0,
        RES_LT = 2'd1,
        RES_EQ = 2'd2
    } result_t;

    // Ceiling log2, usable in localparam expressions
    function automatic int clog2(input int value);
        int result;
        int remaining;
        result    = 0;
        remaining = value - 1;
        while (remaining > 0) begin
            result    = result + 1;
            remaining = remaining >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/digit_comparator.sv
// Purely combinational unsigned compare of one DIGIT-bit slice.
module digit_comparator #(
    parameter int DIGIT = 4
) (
    input  logic [DIGIT-1:0] i_a,
    input  logic [DIGIT-1:0] i_b,
    output logic             o_slice_gt,
    output logic             o_slice_lt,
    output logic             o_slice_eq
);

    assign o_slice_gt = (i_a > i_b);
    assign o_slice_lt = (i_a < i_b);
    assign o_slice_eq = (i_a == i_b);

endmodule

// File: rtl/seq_magnitude_comparator.sv
// Multi-cycle magnitude comparator: scans the captured operands one DIGIT-bit
// slice per cycle, MSB slice first, and registers a GT/LT/EQ verdict.
// Signed operands are handled by flipping the sign bit at capture time, which
// turns a two's-complement compare into an unsigned one.
module seq_magnitude_comparator
    import comparator_pkg::*;
#(
    parameter int WIDTH      = 16,
    parameter int DIGIT      = 4,
    parameter int EARLY_EXIT = 1
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_is_signed,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_gt,
    output logic             o_lt,
    output logic             o_eq
);

    localparam int N    = WIDTH / DIGIT;
    localparam int IDXW = (clog2(N) < 1) ? 1 : clog2(N);
    localparam logic [IDXW-1:0]  LAST_IDX = IDXW'(N - 1);
    localparam logic [WIDTH-1:0] MSB_MASK = WIDTH'(1) << (WIDTH - 1);

    state_t            r_state;
    state_t            w_next_state;
    logic [WIDTH-1:0]  r_a;
    logic [WIDTH-1:0]  r_b;
    logic [IDXW-1:0]   r_idx;
    logic              r_found;
    logic              r_found_gt;
    logic              r_gt;
    logic              r_lt;
    logic              r_eq;

    logic [DIGIT-1:0]  w_slice_a;
    logic [DIGIT-1:0]  w_slice_b;
    logic              w_slice_gt;
    logic              w_slice_lt;
    logic              w_slice_eq;
    logic              w_capture;
    logic              w_finish;
    result_t           w_result;

    // Select slice idx, where idx 0 is the most significant slice
    always_comb begin
        w_slice_a = '0;
        w_slice_b = '0;
        for (int k = 0; k < N; k++) begin
            if (r_idx == IDXW'(k)) begin
                w_slice_a = r_a[(N - 1 - k) * DIGIT +: DIGIT];
                w_slice_b = r_b[(N - 1 - k) * DIGIT +: DIGIT];
            end
        end
    end

    digit_comparator #(
        .DIGIT (DIGIT)
    ) u_digit_comparator (
        .i_a        (w_slice_a),
        .i_b        (w_slice_b),
        .o_slice_gt (w_slice_gt),
        .o_slice_lt (w_slice_lt),
        .o_slice_eq (w_slice_eq)
    );

    assign w_capture = i_start && ((r_state == IDLE) || (r_state == DONE));
    assign w_finish  = (r_state == SCAN) &&
                       ((!w_slice_eq && (EARLY_EXIT != 0)) || (r_idx == LAST_IDX));

    // The first differing slice decides the verdict; later slices never override it
    always_comb begin
        w_result = RES_EQ;
        if (r_found) begin
            w_result = r_found_gt ? RES_GT : RES_LT;
        end else if (w_slice_gt) begin
            w_result = RES_GT;
        end else if (w_slice_lt) begin
            w_result = RES_LT;
        end
    end

    // State register
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic; DONE accepts start just like IDLE for back-to-back use
    always_comb begin
        w_next_state = r_state;
        unique case (r_state)
            IDLE:    w_next_state = i_start ? SCAN : IDLE;
            SCAN:    w_next_state = w_finish ? DONE : SCAN;
            DONE:    w_next_state = i_start ? SCAN : IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // Operand capture, slice walk and verdict registers
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_a        <= '0;
            r_b        <= '0;
            r_idx      <= '0;
            r_found    <= 1'b0;
            r_found_gt <= 1'b0;
            r_gt       <= 1'b0;
            r_lt       <= 1'b0;
            r_eq       <= 1'b0;
        end else if (w_capture) begin
            r_a        <= i_is_signed ? (i_a ^ MSB_MASK) : i_a;
            r_b        <= i_is_signed ? (i_b ^ MSB_MASK) : i_b;
            r_idx      <= '0;
            r_found    <= 1'b0;
            r_found_gt <= 1'b0;
        end else if (r_state == SCAN) begin
            if (!r_found && !w_slice_eq) begin
                r_found    <= 1'b1;
                r_found_gt <= w_slice_gt;
            end
            if (w_finish) begin
                r_gt <= (w_result == RES_GT);
                r_lt <= (w_result == RES_LT);
                r_eq <= (w_result == RES_EQ);
            end else begin
                r_idx <= r_idx + IDXW'(1);
            end
        end
    end

    // Handshake outputs decode the state; verdict outputs come straight from registers
    always_comb begin
        o_busy = (r_state == SCAN);
        o_done = (r_state == DONE);
        o_gt   = r_gt;
        o_lt   = r_lt;
        o_eq   = r_eq;
    end

endmodule

// File: tb/tb_seq_magnitude_comparator.sv
// Scoreboard bench for seq_magnitude_comparator. Three builds run side by side:
// dut 0 = 16/4 early exit, dut 1 = 16/4 full scan, dut 2 = 16/16 single slice.
module tb_seq_magnitude_comparator;

    localparam logic [2:0] GT = 3'b100;
    localparam logic [2:0] LT = 3'b010;
    localparam logic [2:0] EQ = 3'b001;

    typedef struct {
        logic [2:0] res;
        int         issue;
        int         lat;
    } expect_t;

    logic        clk;
    logic        rst;
    logic [2:0]  start;
    logic [15:0] aIn [3];
    logic [15:0] bIn [3];
    logic [2:0]  sIn;
    logic [2:0]  busy;
    logic [2:0]  done;
    logic [2:0]  gt;
    logic [2:0]  lt;
    logic [2:0]  eq;

    int checks;
    int errors;
    int cycleCount;

    expect_t q0[$];
    expect_t q1[$];
    expect_t q2[$];

    seq_magnitude_comparator #(.WIDTH(16), .DIGIT(4), .EARLY_EXIT(1)) u_dut0 (
        .i_clk(clk), .i_rst(rst), .i_start(start[0]), .i_a(aIn[0]), .i_b(bIn[0]),
        .i_is_signed(sIn[0]), .o_busy(busy[0]), .o_done(done[0]),
        .o_gt(gt[0]), .o_lt(lt[0]), .o_eq(eq[0])
    );

    seq_magnitude_comparator #(.WIDTH(16), .DIGIT(4), .EARLY_EXIT(0)) u_dut1 (
        .i_clk(clk), .i_rst(rst), .i_start(start[1]), .i_a(aIn[1]), .i_b(bIn[1]),
        .i_is_signed(sIn[1]), .o_busy(busy[1]), .o_done(done[1]),
        .o_gt(gt[1]), .o_lt(lt[1]), .o_eq(eq[1])
    );

    seq_magnitude_comparator #(.WIDTH(16), .DIGIT(16), .EARLY_EXIT(1)) u_dut2 (
        .i_clk(clk), .i_rst(rst), .i_start(start[2]), .i_a(aIn[2]), .i_b(bIn[2]),
        .i_is_signed(sIn[2]), .o_busy(busy[2]), .o_done(done[2]),
        .o_gt(gt[2]), .o_lt(lt[2]), .o_eq(eq[2])
    );

    // Free-running clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Cycle index used to measure start-to-done latency
    initial begin
        cycleCount = 0;
        forever begin
            @(posedge clk);
            cycleCount = cycleCount + 1;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic int qSize(input int k);
        case (k)
            0:       return q0.size();
            1:       return q1.size();
            default: return q2.size();
        endcase
    endfunction

    task automatic pushExpect(input int k, input logic [2:0] res, input int lat);
        expect_t e;
        e.res   = res;
        e.issue = cycleCount;
        e.lat   = lat;
        case (k)
            0:       q0.push_back(e);
            1:       q1.push_back(e);
            default: q2.push_back(e);
        endcase
    endtask

    // Called just after a rising edge; raises start for exactly one cycle
    task automatic applyStimulus(input int k, input logic [15:0] a, input logic [15:0] b,
                                 input logic s, input logic [2:0] res, input int lat);
        aIn[k]   = a;
        bIn[k]   = b;
        sIn[k]   = s;
        start[k] = 1'b1;
        pushExpect(k, res, lat);
        @(posedge clk);
        #1;
        start[k] = 1'b0;
    endtask

    // Wait, bounded, until every expected result of dut k has been seen
    task automatic waitDrain(input int k);
        for (int i = 0; i < 40 && qSize(k) != 0; i++) begin
            @(posedge clk);
            #1;
        end
        if (qSize(k) != 0) begin
            checks = checks + 1;
            errors = errors + 1;
            $display("[TB] FAIL dut%0d timeout pending=%0d required=0", k, qSize(k));
            case (k)
                0:       q0.delete();
                1:       q1.delete();
                default: q2.delete();
            endcase
        end
    endtask

    function automatic logic [2:0] refCompare(input logic [15:0] a, input logic [15:0] b, input logic s);
        if (s) begin
            if ($signed(a) > $signed(b)) return GT;
            if ($signed(a) < $signed(b)) return LT;
            return EQ;
        end
        if (a > b) return GT;
        if (a < b) return LT;
        return EQ;
    endfunction

    // Monitor: every done pulse pops the oldest expectation of that dut
    initial begin
        forever begin
            @(negedge clk);
            for (int k = 0; k < 3; k++) begin
                if (done[k]) begin
                    expect_t e;
                    bit      have;
                    have = 1'b0;
                    case (k)
                        0:       if (q0.size() > 0) begin e = q0.pop_front(); have = 1'b1; end
                        1:       if (q1.size() > 0) begin e = q1.pop_front(); have = 1'b1; end
                        default: if (q2.size() > 0) begin e = q2.pop_front(); have = 1'b1; end
                    endcase
                    if (!have) begin
                        checks = checks + 1;
                        errors = errors + 1;
                        $display("[TB] FAIL dut%0d unexpected done at cycle %0d required none", k, cycleCount);
                    end else begin
                        checkOutput($sformatf("dut%0d verdict", k), {29'd0, gt[k], lt[k], eq[k]}, {29'd0, e.res});
                        checkOutput($sformatf("dut%0d latency", k), cycleCount - e.issue, e.lat);
                    end
                end
            end
        end
    end

    // Directed sequence
    initial begin
        logic [15:0] ra;
        logic [15:0] rb;
        logic        rs;
        checks = 0;
        errors = 0;
        rst    = 1'b1;
        start  = '0;
        sIn    = '0;
        for (int k = 0; k < 3; k++) begin
            aIn[k] = '0;
            bIn[k] = '0;
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            checkOutput($sformatf("dut%0d reset outputs", k), {27'd0, busy[k], done[k], gt[k], lt[k], eq[k]}, 32'd0);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Equal operands scan every slice; busy spans cycles 1..4
        aIn[0] = 16'h1234; bIn[0] = 16'h1234; sIn[0] = 1'b0; start[0] = 1'b1;
        pushExpect(0, EQ, 5);
        @(posedge clk);
        #1;
        start[0] = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            checkOutput($sformatf("test1 busy cycle %0d", k), {31'd0, busy[0]}, (k <= 4) ? 32'd1 : 32'd0);
            @(posedge clk);
            #1;
        end
        waitDrain(0);
        @(negedge clk);
        checkOutput("test1 verdict held", {29'd0, gt[0], lt[0], eq[0]}, {29'd0, EQ});
        @(posedge clk);
        #1;

        // Sign bit decides in the MSB slice
        applyStimulus(0, 16'h8000, 16'h7FFF, 1'b0, GT, 2);
        waitDrain(0);
        applyStimulus(0, 16'h8000, 16'h7FFF, 1'b1, LT, 2);
        waitDrain(0);

        // Difference in slice 2: early exit vs full scan
        applyStimulus(0, 16'h12F0, 16'h12E0, 1'b0, GT, 4);
        waitDrain(0);
        applyStimulus(1, 16'h12F0, 16'h12E0, 1'b0, GT, 5);
        waitDrain(1);
        applyStimulus(1, 16'h8000, 16'h7FFF, 1'b1, LT, 5);
        waitDrain(1);
        applyStimulus(1, 16'h0F00, 16'h0EFF, 1'b0, GT, 5);
        waitDrain(1);

        // Start held high: ignored in SCAN, accepted again in DONE
        aIn[0] = 16'hFFFF; bIn[0] = 16'h0000; sIn[0] = 1'b1; start[0] = 1'b1;
        pushExpect(0, LT, 2);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        pushExpect(0, LT, 2);
        @(posedge clk);
        #1;
        start[0] = 1'b0;
        waitDrain(0);

        // Reset in cycle 2 of a compare aborts it and clears the verdict
        aIn[0] = 16'h1234; bIn[0] = 16'h1234; sIn[0] = 1'b0; start[0] = 1'b1;
        @(posedge clk);
        #1;
        start[0] = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checkOutput("test5 outputs after reset", {27'd0, busy[0], done[0], gt[0], lt[0], eq[0]}, 32'd0);
        @(posedge clk);
        #1;
        applyStimulus(0, 16'h0001, 16'h0002, 1'b0, LT, 5);
        waitDrain(0);

        // Single-slice build always takes two cycles
        applyStimulus(2, 16'h0005, 16'h0003, 1'b0, GT, 2);
        waitDrain(2);
        applyStimulus(2, 16'hFFFF, 16'h0001, 1'b1, LT, 2);
        waitDrain(2);
        for (int i = 0; i < 8; i++) begin
            ra = 16'($urandom);
            rb = (i == 3) ? ra : 16'($urandom);
            rs = i[0];
            applyStimulus(2, ra, rb, rs, refCompare(ra, rb, rs), 2);
            waitDrain(2);
        end
        for (int i = 0; i < 4; i++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            rs = i[0];
            applyStimulus(1, ra, rb, rs, refCompare(ra, rb, rs), 5);
            waitDrain(1);
        end

        repeat (3) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
